wait_sequencer: RTL and testbench

//  Sequences program-counter advance for the CPU's wait instructions. Synchronises the

---
 rtl/wait_sequencer.sv | 145 ++++++++++++++
 tb/tb_wait_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_sequencer.sv
// Wait-instruction sequencer: synchronises ready_in/in_port, buffers edges, gates pc_en (combinational).
// Release data lands on sw_data one cycle after the release edge; a bounded counter forces release on a dead handshake.
module wait_sequencer #(
  parameter int BUS_WIDTH      = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 ready_in,
  input  logic [BUS_WIDTH-1:0] in_port,
  input  logic                 wait_req,
  input  logic                 wait_edge,
  input  logic                 wait_pol,
  output logic                 pc_en,
  output logic [BUS_WIDTH-1:0] sw_data,
  output logic                 sw_valid,
  output logic                 timeout
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam bit                     LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] LP_TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] LP_CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_ready_sync;
  logic [BUS_WIDTH-1:0]   r_data_sync [SYNC_STAGES];
  logic                   r_ready_p;
  logic                   r_rise_pend;
  logic                   r_fall_pend;
  logic [BUS_WIDTH-1:0]   r_pend_data;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic [0:0]             r_state;

  logic                   w_ready_s;
  logic [BUS_WIDTH-1:0]   w_data_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_live;
  logic                   w_pend_sel;
  logic                   w_cond;
  logic [BUS_WIDTH-1:0]   w_cap_data;
  logic [0:0]             w_state_nxt;
  logic                   w_capture;
  logic                   w_to_fire;
  logic                   w_cnt_clr;
  logic                   w_cnt_inc;
  logic                   w_consume_rise;
  logic                   w_consume_fall;

  // Data travels through a chain of the same depth as ready, so both are sampled together.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_ready_sync <= '0;
      r_ready_p    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
    end else begin
      r_ready_sync   <= {r_ready_sync[SYNC_STAGES-2:0], ready_in};
      r_ready_p      <= r_ready_sync[SYNC_STAGES-1];
      r_data_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
    end
  end

  assign w_ready_s = r_ready_sync[SYNC_STAGES-1];
  assign w_data_s  = r_data_sync[SYNC_STAGES-1];
  assign w_rise    = w_ready_s & ~r_ready_p;
  assign w_fall    = ~w_ready_s & r_ready_p;

  assign w_live     = wait_pol ? w_fall : w_rise;
  assign w_pend_sel = wait_pol ? r_fall_pend : r_rise_pend;
  assign w_cond     = wait_edge ? (w_live | w_pend_sel) : (w_ready_s == ~wait_pol);
  assign w_cap_data = (wait_edge && !w_live) ? r_pend_data : w_data_s;

  always_comb begin
    w_state_nxt = r_state;
    pc_en       = 1'b1;
    w_capture   = 1'b0;
    w_to_fire   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (wait_req) begin
          if (w_cond) begin
            w_capture = 1'b1;
          end else begin
            pc_en       = 1'b0;
            w_state_nxt = ST_WAIT;
            w_cnt_clr   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A real release beats an expiring counter in the same cycle.
        if (!wait_req) begin
          w_state_nxt = ST_RUN;
        end else if (w_cond) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (LP_TO_EN && (r_cnt == LP_TO_LAST)) begin
          w_to_fire   = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          pc_en     = 1'b0;
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_consume_rise = w_capture & wait_edge & ~wait_pol;
  assign w_consume_fall = w_capture & wait_edge & wait_pol;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= ST_RUN;
      r_rise_pend <= 1'b0;
      r_fall_pend <= 1'b0;
      r_pend_data <= '0;
      r_cnt       <= '0;
      sw_data     <= '0;
      sw_valid    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rise_pend <= w_consume_rise ? 1'b0 : (r_rise_pend | w_rise);
      r_fall_pend <= w_consume_fall ? 1'b0 : (r_fall_pend | w_fall);
      if (w_rise || w_fall) r_pend_data <= w_data_s;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != LP_CNT_MAX)) begin
        r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
      end
      sw_valid <= w_capture;
      timeout  <= w_to_fire;
      if (w_capture) sw_data <= w_cap_data;
    end
  end

endmodule

// File: tb/tb_wait_sequencer.sv
// Directed bench for wait_sequencer: pc_en checked per cycle, sw_valid/timeout pulses via a scoreboard queue.
module tb_wait_sequencer;

  typedef struct packed {
    logic       is_to;
    logic [7:0] data;
  } sb_t;

  logic       clk;
  logic       n_reset;
  logic       ready_in;
  logic [7:0] in_port;
  logic       wait_req;
  logic       wait_edge;
  logic       wait_pol;
  logic       sel_b;

  logic       pc_en_a, sw_valid_a, timeout_a;
  logic [7:0] sw_data_a;
  logic       pc_en_b, sw_valid_b, timeout_b;
  logic [7:0] sw_data_b;

  logic       pc_en_s, sv_s, to_s;
  logic [7:0] sw_data_s;

  int  n_checks = 0;
  int  n_fail   = 0;
  sb_t exp_q[$];
  sb_t mon_e;

  wait_sequencer dut_a (
    .clk(clk), .n_reset(n_reset), .ready_in(ready_in), .in_port(in_port),
    .wait_req(wait_req), .wait_edge(wait_edge), .wait_pol(wait_pol),
    .pc_en(pc_en_a), .sw_data(sw_data_a), .sw_valid(sw_valid_a), .timeout(timeout_a)
  );

  wait_sequencer #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .n_reset(n_reset), .ready_in(ready_in), .in_port(in_port),
    .wait_req(wait_req), .wait_edge(wait_edge), .wait_pol(wait_pol),
    .pc_en(pc_en_b), .sw_data(sw_data_b), .sw_valid(sw_valid_b), .timeout(timeout_b)
  );

  assign pc_en_s   = sel_b ? pc_en_b   : pc_en_a;
  assign sv_s      = sel_b ? sw_valid_b : sw_valid_a;
  assign to_s      = sel_b ? timeout_b : timeout_a;
  assign sw_data_s = sel_b ? sw_data_b : sw_data_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic exp_pc, input string name);
    @(negedge clk);
    chk(name, {7'd0, pc_en_s}, {7'd0, exp_pc});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  task automatic push(input logic is_to, input logic [7:0] data);
    sb_t e;
    e.is_to = is_to;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse on the selected DUT must match the next expected event.
  always @(negedge clk) begin
    if (n_reset && (sv_s || to_s)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: sw_valid=%0b timeout=%0b sw_data=%h, expected no event", sv_s, to_s, sw_data_s);
      end else begin
        mon_e = exp_q.pop_front();
        if (sv_s !== !mon_e.is_to || to_s !== mon_e.is_to || sw_data_s !== mon_e.data) begin
          n_fail++;
          $display("FAIL sb_event: got sw_valid=%0b timeout=%0b sw_data=%h, expected sw_valid=%0b timeout=%0b sw_data=%h",
                   sv_s, to_s, sw_data_s, !mon_e.is_to, mon_e.is_to, mon_e.data);
        end
      end
    end
  end

  initial begin
    n_reset   = 1'b0;
    ready_in  = 1'b0;
    in_port   = 8'h00;
    wait_req  = 1'b0;
    wait_edge = 1'b0;
    wait_pol  = 1'b0;
    sel_b     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_sw_data_a", sw_data_a, 8'h00);
    chk("rst_sw_valid_a", {7'd0, sw_valid_a}, 8'h00);
    chk("rst_timeout_a", {7'd0, timeout_a}, 8'h00);
    chk("rst_pc_en_a", {7'd0, pc_en_a}, 8'h01);
    chk("rst_sw_data_b", sw_data_b, 8'h00);
    @(posedge clk);
    #1;

    // T1 level wait, high
    wait_req = 1'b1; wait_edge = 1'b0; wait_pol = 1'b0;
    push(1'b0, 8'hA5);
    repeat (5) step(1'b0, "t1_stall");
    ready_in = 1'b1; in_port = 8'hA5;
    step(1'b0, "t1_sync1");
    step(1'b0, "t1_sync2");
    step(1'b1, "t1_release");
    wait_req = 1'b0;
    step(1'b1, "t1_run");
    step(1'b1, "t1_run");
    chk("t1_sw_data_hold", sw_data_a, 8'hA5);

    // T2 buffered rising edge, zero-stall wait
    ready_in = 1'b0; wait_req = 1'b0;
    do_reset();
    ready_in = 1'b1; in_port = 8'h3C;
    repeat (3) step(1'b1, "t2_pulse");
    ready_in = 1'b0;
    repeat (10) step(1'b1, "t2_idle");
    wait_req = 1'b1; wait_edge = 1'b1; wait_pol = 1'b0;
    push(1'b0, 8'h3C);
    step(1'b1, "t2_zero_stall");
    step(1'b0, "t2_pend_cleared");
    wait_req = 1'b0;
    step(1'b1, "t2_drop_release");

    // T5 falling edge with pol=1; rise_pend must survive
    do_reset();
    ready_in = 1'b1; in_port = 8'h11;
    repeat (4) step(1'b1, "t5_idle");
    wait_req = 1'b1; wait_edge = 1'b1; wait_pol = 1'b1;
    push(1'b0, 8'h0F);
    step(1'b0, "t5_stall");
    step(1'b0, "t5_stall");
    ready_in = 1'b0; in_port = 8'h0F;
    step(1'b0, "t5_sync1");
    step(1'b0, "t5_sync2");
    step(1'b1, "t5_fall_release");
    wait_pol = 1'b0;
    push(1'b0, 8'h0F);
    step(1'b1, "t5_rise_pend_kept");
    wait_req = 1'b0;
    ready_in = 1'b1; in_port = 8'hF0;
    repeat (4) step(1'b1, "t5_idle2");
    wait_req = 1'b1; wait_edge = 1'b1; wait_pol = 1'b0;
    push(1'b0, 8'hF0);
    step(1'b1, "t5_later_rise");
    wait_req = 1'b0;
    step(1'b1, "t5_run");
    step(1'b1, "t5_run");

    // T4 collision on the expiry cycle (TIMEOUT_CYCLES=4 instance)
    sel_b = 1'b1;
    ready_in = 1'b0; in_port = 8'h00;
    do_reset();
    wait_req = 1'b1; wait_edge = 1'b1; wait_pol = 1'b0;
    step(1'b0, "t4_enter");
    step(1'b0, "t4_cnt0");
    ready_in = 1'b1; in_port = 8'h77;
    push(1'b0, 8'h77);
    step(1'b0, "t4_cnt1");
    step(1'b0, "t4_cnt2");
    step(1'b1, "t4_collision");
    wait_req = 1'b0; ready_in = 1'b0;
    repeat (5) step(1'b1, "t4_idle");

    // T3 timeout, sw_data must keep 77
    wait_req = 1'b1; wait_edge = 1'b1; wait_pol = 1'b0;
    push(1'b1, 8'h77);
    repeat (4) step(1'b0, "t3_stall");
    step(1'b1, "t3_expire");
    wait_req = 1'b0;
    step(1'b1, "t3_run");
    step(1'b1, "t3_run");
    chk("t3_sw_data_hold", sw_data_b, 8'h77);

    // T6 reset mid-WAIT with rise_pend set
    sel_b = 1'b0;
    do_reset();
    ready_in = 1'b1; in_port = 8'h22;
    repeat (4) step(1'b1, "t6_idle");
    wait_req = 1'b1; wait_edge = 1'b1; wait_pol = 1'b1;
    step(1'b0, "t6_enter");
    step(1'b0, "t6_in_wait");
    n_reset = 1'b0; ready_in = 1'b0; wait_pol = 1'b0;
    #1;
    chk("t6_rst_pc_en", {7'd0, pc_en_a}, 8'h00);
    chk("t6_rst_sw_valid", {7'd0, sw_valid_a}, 8'h00);
    chk("t6_rst_timeout", {7'd0, timeout_a}, 8'h00);
    chk("t6_rst_sw_data", sw_data_a, 8'h00);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (3) step(1'b0, "t6_no_stale_edge");
    ready_in = 1'b1; in_port = 8'h5A;
    push(1'b0, 8'h5A);
    step(1'b0, "t6_sync1");
    step(1'b0, "t6_sync2");
    step(1'b1, "t6_fresh_edge");
    wait_req = 1'b0;
    step(1'b1, "t6_run");
    step(1'b1, "t6_run");
    chk("t6_sw_data", sw_data_a, 8'h5A);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d events still expected, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
